// File: rtl/huc_mem_ctrl.sv
// HuCard memory controller: one timed external SRAM/PSRAM cycle per ROM/RAM request edge.
// Optional single-entry read word cache compiled in with `define MEM_WORD_CACHE_EN.
module huc_mem_ctrl #(
  parameter int unsigned RD_CYC = 7,
  parameter int unsigned WR_CYC = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rom_addr,
  input  logic [7:0]  rom_dati,
  input  logic        rom_ce,
  input  logic        rom_oe,
  input  logic        rom_we,
  input  logic [23:0] ram_addr,
  input  logic [7:0]  ram_dati,
  input  logic        ram_ce,
  input  logic        ram_oe,
  input  logic        ram_we,
  output logic [7:0]  rom_dato,
  output logic [7:0]  ram_dato,
  output logic        busy,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_dq_o,
  input  logic [15:0] mem_dq_i,
  output logic        mem_dq_oe,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WSU  = 3'd2;
  localparam logic [2:0] S_WP   = 3'd3;
  localparam logic [2:0] S_WH   = 3'd4;
  localparam logic [2:0] S_REC  = 3'd5;

  logic        rom_req, ram_req, rom_rise, ram_rise;
  logic        rom_req_q, ram_req_q;
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        chan_q, chan_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        rom_pend_q, rom_pend_d, ram_pend_q, ram_pend_d;
  logic [23:0] rom_paddr_q, rom_paddr_d, ram_paddr_q, ram_paddr_d;
  logic [7:0]  rom_pdata_q, rom_pdata_d, ram_pdata_q, ram_pdata_d;
  logic        rom_pwr_q, rom_pwr_d, ram_pwr_q, ram_pwr_d;
  logic [7:0]  rom_dato_q, rom_dato_d, ram_dato_q, ram_dato_d;
  logic        st_go, st_ch, st_wr;
  logic [23:0] st_addr;
  logic [7:0]  st_data;
  logic [7:0]  rd_byte;
  logic        act;
`ifdef MEM_WORD_CACHE_EN
  logic        cv_q, cv_d;
  logic [22:0] ctag_q, ctag_d;
  logic [15:0] cword_q, cword_d;
  logic        c_hit;
  logic [7:0]  c_byte;
`endif

  assign rom_req  = rom_ce & (rom_oe | rom_we);
  assign ram_req  = ram_ce & (ram_oe | ram_we);
  assign rom_rise = rom_req & ~rom_req_q;
  assign ram_rise = ram_req & ~ram_req_q;
  assign rd_byte  = addr_q[0] ? mem_dq_i[15:8] : mem_dq_i[7:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chan_d      = chan_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rom_pend_d  = rom_pend_q;
    ram_pend_d  = ram_pend_q;
    rom_paddr_d = rom_paddr_q;
    ram_paddr_d = ram_paddr_q;
    rom_pdata_d = rom_pdata_q;
    ram_pdata_d = ram_pdata_q;
    rom_pwr_d   = rom_pwr_q;
    ram_pwr_d   = ram_pwr_q;
    rom_dato_d  = rom_dato_q;
    ram_dato_d  = ram_dato_q;
    st_go       = 1'b0;
    st_ch       = 1'b0;
    st_wr       = 1'b0;
    st_addr     = '0;
    st_data     = '0;
`ifdef MEM_WORD_CACHE_EN
    cv_d        = cv_q;
    ctag_d      = ctag_q;
    cword_d     = cword_q;
`endif

    // Launch selection: ROM (pending or fresh) outranks RAM.
    if (state_q == S_IDLE) begin
      if (rom_pend_q) begin
        st_go = 1'b1; st_ch = 1'b0;
        st_addr = rom_paddr_q; st_data = rom_pdata_q; st_wr = rom_pwr_q;
      end else if (rom_rise) begin
        st_go = 1'b1; st_ch = 1'b0;
        st_addr = rom_addr; st_data = rom_dati; st_wr = rom_we;
      end else if (ram_pend_q) begin
        st_go = 1'b1; st_ch = 1'b1;
        st_addr = ram_paddr_q; st_data = ram_pdata_q; st_wr = ram_pwr_q;
      end else if (ram_rise) begin
        st_go = 1'b1; st_ch = 1'b1;
        st_addr = ram_addr; st_data = ram_dati; st_wr = ram_we;
      end
    end

`ifdef MEM_WORD_CACHE_EN
    c_hit  = st_go && !st_wr && cv_q && (ctag_q == st_addr[23:1]);
    c_byte = st_addr[0] ? cword_q[15:8] : cword_q[7:0];
`endif

    if (st_go && !st_ch) rom_pend_d = 1'b0;
    if (st_go &&  st_ch) ram_pend_d = 1'b0;

    // An edge on the channel not being served is parked with its request captured.
    if (rom_rise && !rom_pend_q && (state_q != S_IDLE) && chan_q) begin
      rom_pend_d = 1'b1;
      rom_paddr_d = rom_addr; rom_pdata_d = rom_dati; rom_pwr_d = rom_we;
    end
    if (ram_rise && !ram_pend_q &&
        (((state_q != S_IDLE) && !chan_q) || (st_go && !st_ch))) begin
      ram_pend_d = 1'b1;
      ram_paddr_d = ram_addr; ram_pdata_d = ram_dati; ram_pwr_d = ram_we;
    end

    if (st_go) begin
`ifdef MEM_WORD_CACHE_EN
      if (st_wr) cv_d = 1'b0;
      if (c_hit) begin
        if (st_ch) ram_dato_d = c_byte;
        else       rom_dato_d = c_byte;
      end else
`endif
      begin
        chan_d  = st_ch;
        addr_d  = st_addr;
        data_d  = st_data;
        state_d = st_wr ? S_WSU : S_RD;
        cnt_d   = 4'(RD_CYC - 1);
      end
    end

    case (state_q)
      S_IDLE: ;
      S_RD: begin
        if (cnt_q == '0) begin
          state_d = S_REC;
          if (chan_q) ram_dato_d = rd_byte;
          else        rom_dato_d = rd_byte;
`ifdef MEM_WORD_CACHE_EN
          cv_d    = 1'b1;
          ctag_d  = addr_q[23:1];
          cword_d = mem_dq_i;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WSU: begin
        state_d = S_WP;
        cnt_d   = 4'(WR_CYC - 1);
      end
      S_WP: begin
        if (cnt_q == '0) state_d = S_WH;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_WH:    state_d = S_REC;
      S_REC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      chan_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rom_req_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      rom_pend_q  <= 1'b0;
      ram_pend_q  <= 1'b0;
      rom_paddr_q <= '0;
      ram_paddr_q <= '0;
      rom_pdata_q <= '0;
      ram_pdata_q <= '0;
      rom_pwr_q   <= 1'b0;
      ram_pwr_q   <= 1'b0;
      rom_dato_q  <= '1;
      ram_dato_q  <= '1;
`ifdef MEM_WORD_CACHE_EN
      cv_q        <= 1'b0;
      ctag_q      <= '0;
      cword_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rom_req_q   <= rom_req;
      ram_req_q   <= ram_req;
      rom_pend_q  <= rom_pend_d;
      ram_pend_q  <= ram_pend_d;
      rom_paddr_q <= rom_paddr_d;
      ram_paddr_q <= ram_paddr_d;
      rom_pdata_q <= rom_pdata_d;
      ram_pdata_q <= ram_pdata_d;
      rom_pwr_q   <= rom_pwr_d;
      ram_pwr_q   <= ram_pwr_d;
      rom_dato_q  <= rom_dato_d;
      ram_dato_q  <= ram_dato_d;
`ifdef MEM_WORD_CACHE_EN
      cv_q        <= cv_d;
      ctag_q      <= ctag_d;
      cword_q     <= cword_d;
`endif
    end
  end

  // Memory strobes decode straight from the state register so reset releases them at once.
  assign act       = (state_q == S_RD) || (state_q == S_WSU) ||
                     (state_q == S_WP) || (state_q == S_WH);
  assign busy      = (state_q != S_IDLE);
  assign mem_ce_n  = ~act;
  assign mem_oe_n  = ~(state_q == S_RD);
  assign mem_we_n  = ~(state_q == S_WP);
  assign mem_dq_oe = (state_q == S_WSU) || (state_q == S_WP) || (state_q == S_WH);
  assign mem_lb_n  = ~(act & ~addr_q[0]);
  assign mem_ub_n  = ~(act &  addr_q[0]);
  assign mem_addr  = addr_q[23:1];
  assign mem_dq_o  = {data_q, data_q};
  assign rom_dato  = rom_dato_q;
  assign ram_dato  = ram_dato_q;

endmodule

// File: tb/tb_huc_mem_ctrl.sv
// Directed bench for huc_mem_ctrl with a read scoreboard fed by a behavioural SRAM pattern.
module tb_huc_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] rom_addr, ram_addr;
  logic [7:0]  rom_dati, ram_dati;
  logic        rom_ce, rom_oe, rom_we, ram_ce, ram_oe, ram_we;
  logic [7:0]  rom_dato, ram_dato;
  logic        busy;
  logic [22:0] mem_addr;
  logic [15:0] mem_dq_o, mem_dq_i;
  logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;
  int viol   = 0;
  logic [8:0] sb[$];
  logic [8:0] sb_e;
  logic       prev_oe_n = 1'b1;

  always #5 clk = ~clk;

  huc_mem_ctrl #(.RD_CYC(7), .WR_CYC(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_addr(rom_addr), .rom_dati(rom_dati), .rom_ce(rom_ce), .rom_oe(rom_oe), .rom_we(rom_we),
    .ram_addr(ram_addr), .ram_dati(ram_dati), .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
    .rom_dato(rom_dato), .ram_dato(ram_dato), .busy(busy),
    .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_i(mem_dq_i), .mem_dq_oe(mem_dq_oe),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n)
  );

  function automatic logic [15:0] model_word(input logic [22:0] a);
    if (a == 23'h7F0001) return 16'hA55A;
    return {a[7:0] ^ 8'h5A, a[7:0] ^ 8'hC3};
  endfunction

  function automatic logic [7:0] model_byte(input logic [23:0] ba);
    logic [15:0] w;
    w = model_word(ba[23:1]);
    return ba[0] ? w[15:8] : w[7:0];
  endfunction

  assign mem_dq_i = model_word(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Read completions pop the scoreboard on the first cycle after mem_oe_n releases.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oe_n = 1'b1;
    end else begin
      if (!mem_oe_n && !mem_we_n) viol++;
      if (mem_dq_oe && !mem_oe_n) viol++;
      if (!prev_oe_n && mem_oe_n) begin
        if (sb.size() == 0) begin
          chk("sb_has_entry", 32'(sb.size()), 32'd1);
        end else begin
          sb_e = sb.pop_front();
          if (sb_e[8]) chk("sb_ram_dato", {24'd0, ram_dato}, {24'd0, sb_e[7:0]});
          else         chk("sb_rom_dato", {24'd0, rom_dato}, {24'd0, sb_e[7:0]});
        end
      end
      prev_oe_n = mem_oe_n;
    end
  end

  initial begin
    logic [9:0]  we_pat, oe_pat, ce_pat;
    logic [19:0] rd_pat, bz_pat;
    int          falls;
    logic        prev_ce;

    rst_n = 1'b0;
    rom_addr = '0; rom_dati = '0; rom_ce = 1'b0; rom_oe = 1'b0; rom_we = 1'b0;
    ram_addr = '0; ram_dati = '0; ram_ce = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;

    // Reset state
    tick(2);
    chk("rst_ctrls", {27'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}, 32'h1F);
    chk("rst_dq_oe", {31'd0, mem_dq_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_datos", {16'd0, rom_dato, ram_dato}, 32'h0000FFFF);
    chk("rst_addr_dq", {9'd0, mem_addr} | {16'd0, mem_dq_o}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ce_n", {31'd0, mem_ce_n}, 32'd1);

    // ROM read, upper lane
    rom_addr = 24'hFE0003; rom_ce = 1'b1; rom_oe = 1'b1;
    sb.push_back({1'b0, model_byte(24'hFE0003)});
    tick(1);
    chk("rd_addr", {9'd0, mem_addr}, 32'h7F0001);
    chk("rd_lanes", {30'd0, mem_lb_n, mem_ub_n}, 32'b10);
    chk("rd_start", {29'd0, mem_ce_n, mem_oe_n, busy}, 32'b001);
    tick(6);
    chk("rd_oe_t7", {31'd0, mem_oe_n}, 32'd0);
    tick(1);
    chk("rd_rec_t8", {29'd0, mem_oe_n, mem_ce_n, busy}, 32'b111);
    chk("rd_dato_t8", {24'd0, rom_dato}, 32'hA5);
    tick(1);
    chk("rd_idle_t9", {31'd0, busy}, 32'd0);
    rom_ce = 1'b0; rom_oe = 1'b0;
    tick(2);

    // RAM write; request drops and inputs change mid-cycle
    ram_addr = 24'h000010; ram_dati = 8'h3C; ram_ce = 1'b1; ram_we = 1'b1;
    we_pat = '0; oe_pat = '0; ce_pat = '0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      we_pat[k-1] = ~mem_we_n;
      oe_pat[k-1] = mem_dq_oe;
      ce_pat[k-1] = ~mem_ce_n;
      if (k == 1) begin
        chk("wr_lanes", {30'd0, mem_lb_n, mem_ub_n}, 32'b01);
        chk("wr_dq_o", {16'd0, mem_dq_o}, 32'h3C3C);
        chk("wr_addr", {9'd0, mem_addr}, 32'h8);
      end
      if (k == 3) begin
        ram_ce = 1'b0; ram_we = 1'b0; ram_dati = 8'h99; ram_addr = 24'h000FFF;
      end
      if (k == 8) begin
        chk("wr_wh_hold", {9'd0, mem_addr} ^ {16'd0, mem_dq_o}, 32'h8 ^ 32'h3C3C);
      end
    end
    chk("wr_we_pulse", {22'd0, we_pat}, 32'h07E);
    chk("wr_dq_oe_win", {22'd0, oe_pat}, 32'h0FF);
    chk("wr_ce_win", {22'd0, ce_pat}, 32'h0FF);
    tick(2);

    // Simultaneous ROM and RAM read edges
    rom_addr = 24'h000005; rom_ce = 1'b1; rom_oe = 1'b1;
    ram_addr = 24'h000020; ram_ce = 1'b1; ram_oe = 1'b1;
    sb.push_back({1'b0, model_byte(24'h000005)});
    sb.push_back({1'b1, model_byte(24'h000020)});
    rd_pat = '0; bz_pat = '0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      rd_pat[k-1] = ~mem_oe_n;
      bz_pat[k-1] = busy;
      if (k == 1)  chk("dual_rom_addr", {9'd0, mem_addr}, 32'h2);
      if (k == 10) chk("dual_ram_addr", {9'd0, mem_addr}, 32'h10);
    end
    chk("dual_oe_pat", {12'd0, rd_pat}, 32'h0FE7F);
    chk("dual_busy_pat", {12'd0, bz_pat}, 32'h1FEFF);
    chk("dual_datos", {16'd0, rom_dato, ram_dato},
        {16'd0, model_byte(24'h000005), model_byte(24'h000020)});
    rom_ce = 1'b0; rom_oe = 1'b0; ram_ce = 1'b0; ram_oe = 1'b0;
    tick(2);

    // Request held for 100 cycles
    rom_addr = 24'h000040; rom_ce = 1'b1; rom_oe = 1'b1;
    sb.push_back({1'b0, model_byte(24'h000040)});
    falls = 0; prev_ce = mem_ce_n;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (prev_ce && !mem_ce_n) falls++;
      prev_ce = mem_ce_n;
    end
    chk("held_one_cycle", 32'(falls), 32'd1);
    rom_ce = 1'b0; rom_oe = 1'b0;
    tick(3);

    // Asynchronous reset during the write pulse
    rom_addr = 24'h000011; rom_dati = 8'h77; rom_ce = 1'b1; rom_we = 1'b1;
    tick(4);
    chk("wp_active", {30'd0, mem_we_n, mem_dq_oe}, 32'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_oe", {30'd0, mem_we_n, mem_dq_oe}, 32'b10);
    chk("arst_ce_busy", {30'd0, mem_ce_n, busy}, 32'b10);
    chk("arst_rom_dato", {24'd0, rom_dato}, 32'hFF);
    rom_ce = 1'b0; rom_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef MEM_WORD_CACHE_EN
    ram_addr = 24'h000100; ram_ce = 1'b1; ram_oe = 1'b1;
    sb.push_back({1'b1, model_byte(24'h000100)});
    tick(12);
    ram_ce = 1'b0; ram_oe = 1'b0;
    tick(2);
    ram_addr = 24'h000101; ram_ce = 1'b1; ram_oe = 1'b1;
    tick(1);
    chk("hit_no_ce", {30'd0, mem_ce_n, busy}, 32'b10);
    chk("hit_dato", {24'd0, ram_dato}, {24'd0, model_byte(24'h000101)});
    ram_ce = 1'b0; ram_oe = 1'b0;
    tick(2);
    rom_addr = 24'h000100; rom_dati = 8'h11; rom_ce = 1'b1; rom_we = 1'b1;
    tick(12);
    rom_ce = 1'b0; rom_we = 1'b0;
    tick(2);
    ram_addr = 24'h000101; ram_ce = 1'b1; ram_oe = 1'b1;
    sb.push_back({1'b1, model_byte(24'h000101)});
    tick(1);
    chk("inval_miss_ce", {30'd0, mem_ce_n, busy}, 32'b01);
    tick(11);
    ram_ce = 1'b0; ram_oe = 1'b0;
    tick(2);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("strobe_rules", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/huc_mem_ctrl.md
# huc_mem_ctrl

Memory controller directly downstream of the HuCard mapper. It consumes the mapper's ROM and RAM request channels and turns each CPU access into one timed cycle on the shared 16-bit external asynchronous SRAM/PSRAM. It returns read bytes on per-channel data outputs, which the mapper muxes onto the cartridge bus. Requests arrive already synchronised to `clk`; each request gets exactly one memory cycle, no matter how long the CPU holds it.

## Interface
Parameters:
- `RD_CYC`, 7: number of `clk` cycles `mem_oe_n` stays low before read data is sampled (1..15).
- `WR_CYC`, 6: width of the `mem_we_n` low pulse, in `clk` cycles (1..15).

Ports:
- `clk` in 1: system clock; all logic runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rom_addr` in 24: ROM physical byte address.
- `rom_dati` in 8: ROM write data.
- `rom_ce`, `rom_oe`, `rom_we` in 1 each: ROM chip enable, read strobe and write strobe.
- `ram_addr` in 24: RAM physical byte address.
- `ram_dati` in 8: RAM write data.
- `ram_ce`, `ram_oe`, `ram_we` in 1 each: RAM chip enable, read strobe and write strobe.
- `rom_dato` out 8: last ROM read byte; held until the next ROM read completes.
- `ram_dato` out 8: last RAM read byte; held until the next RAM read completes.
- `busy` out 1: high while a memory cycle is in progress.
- `mem_addr` out 23: word address, equal to byte address [23:1].
- `mem_dq_o` out 16: write data, with the byte replicated on both lanes.
- `mem_dq_i` in 16: read data from the memory.
- `mem_dq_oe` out 1: enables the data bus output drivers.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`, `mem_lb_n`, `mem_ub_n` out 1 each: active-low memory controls.

## Operation
- Request definition, per channel: `req = ce & (oe | we)`.
- Trigger: a request starts only on the rising edge of `req`, compared against its registered value from the previous cycle.
  - A request held high never retriggers.
- Priority: if both channels rise in the same cycle, ROM is served first. The RAM edge is held pending and served immediately after.
- Edges arriving while busy: a rising edge on the channel not currently being served is latched as pending. A second edge on the same channel while busy is dropped.
- Read vs write: if `we` and `oe` are both high at the trigger, the access is a write.
- Captured at the trigger: address, data, channel and direction. Later input changes do not affect the cycle in flight.
- Byte lane: byte address bit 0 = 0 selects the low byte (`mem_lb_n` = 0); bit 0 = 1 selects the high byte (`mem_ub_n` = 0).
  - Reads sample the selected lane into the `*_dato` of the channel being served.
- State machine:
  - IDLE → RD or WSU, when an edge or pending request exists.
  - RD: holds RD_CYC cycles, then goes to REC.
  - WSU: 1 cycle, then goes to WP.
  - WP: holds WR_CYC cycles, then goes to WH.
  - WH: 1 cycle, then goes to REC.
  - REC: 1 cycle, then goes to IDLE.
- Dropped request: if `req` falls mid-cycle, the cycle still completes in full. A write is never truncated.
- Reset (asynchronous, any state, including mid-write):
  - State returns to IDLE; pending requests are cleared.
  - `mem_ce_n`, `mem_oe_n`, `mem_we_n`, `mem_lb_n`, `mem_ub_n` = 1.
  - `mem_dq_oe` = 0, `busy` = 0, `mem_addr` = 0, `mem_dq_o` = 0.
  - `rom_dato` and `ram_dato` = 8'hFF.

## Timing
- Cycle T: rising edge of `req` is detected.
- T+1: `mem_addr`, `mem_ce_n` = 0 and the lane select become valid; `busy` = 1.
- Read:
  - `mem_oe_n` is low from T+1 through T+RD_CYC.
  - `mem_dq_i` is sampled at the end of T+RD_CYC.
  - `*_dato` is valid at T+RD_CYC+1, and the controls deassert in the same cycle (REC).
  - IDLE is reached at T+RD_CYC+2.
- Write:
  - WSU at T+1: `mem_dq_oe` = 1, `mem_we_n` = 1.
  - `mem_we_n` is low from T+2 through T+WR_CYC+1.
  - WH at T+WR_CYC+2: `mem_we_n` = 1; data, address and `mem_ce_n` are still held.
  - REC: `mem_dq_oe` = 0 and `mem_ce_n` = 1.
- `mem_oe_n` and `mem_we_n` are never low in the same cycle.
- `mem_dq_oe` is high only in WSU, WP and WH.
- A pending request starts in the first IDLE cycle, so consecutive cycles are separated by one REC plus one IDLE.

## Configuration
- `MEM_WORD_CACHE_EN` defined: a single-entry word cache is compiled in.
  - Cache contents: the last read word plus a tag (word address) and a valid bit.
  - Read hit (valid and tag equal): `*_dato` is updated at T+1 from the cached word. No memory cycle runs and `busy` stays 0.
  - Invalidation: any write, hit or miss, clears the valid bit. Reset also clears it.
- `MEM_WORD_CACHE_EN` undefined: every read performs a full memory cycle. No cache registers are present.

## Test plan
- Reset, then idle: all controls = 1, `mem_dq_oe` = 0, `rom_dato` = `ram_dato` = FF, `busy` = 0.
- ROM read at 24'hFE0003 with `mem_dq_i` = 16'hA55A, RD_CYC = 7:
  - `mem_addr` = 23'h7F0001, `mem_ub_n` = 0.
  - `rom_dato` = A5 at T+8; `busy` low at T+9.
- RAM write of 8'h3C to 24'h000010:
  - `mem_we_n` low for exactly 6 cycles; `mem_lb_n` = 0; `mem_dq_o` = 16'h3C3C.
  - `mem_dq_oe` covers the pulse plus one cycle either side.
- Simultaneous rising edges on ROM and RAM reads: the ROM cycle completes first, then the RAM cycle starts, with one REC and one IDLE between them. Both `*_dato` values are correct.
- `req` held high for 100 cycles: exactly one memory cycle. Assert `rst_n` = 0 mid-WP: `mem_we_n` = 1 and `mem_dq_oe` = 0 immediately (asynchronously).
- With `MEM_WORD_CACHE_EN`: read 24'h000100, then read 24'h000101.
  - The second read produces no `mem_ce_n` activity and gives the high byte at T+1.
  - Write to 24'h000100, then read 24'h000101: a full cycle occurs.
